ili9341_driver: RTL and testbench
=================================

// Module: ili9341_driver
// PURPOSE
//  - Top-level ILI9341 TFT controller for the 4-wire SPI panel on the FPGA board: resets and initialises the panel.
//  - Then fills the full 240x320 screen with a solid colour selected by the two board buttons.
//  - Repaints whenever the button value changes.
//  - Sits directly on board pins; no upstream bus interface.
// PARAMETERS
//  CLK_HZ        100_000_000  sysclk frequency, used to derive delays
//  SPI_DIV       4            sysclk cycles per SPI half-period (tft_clk = CLK_HZ/(2*SPI_DIV))
//  DELAY_DIV     1            divides every ms/us delay (set >1 to shorten delays in simulation)
//  DEBOUNCE_CYC  1_000_000    stable-cycles required when ILI9341_DEBOUNCE_EN is defined
// PORTS
//  sysclk   in   1  system clock, all logic on rising edge
//  rst_n    in   1  asynchronous active-low reset
//  btn      in   2  raw buttons, colour select (asynchronous to sysclk)
//  tft_bl   out  1  backlight enable, active high
//  tft_rst  out  1  panel hardware reset, active low
//  tft_dc   out  1  0 = command byte, 1 = data byte
//  tft_cs   out  1  SPI chip select, active low
//  tft_clk  out  1  SPI clock, mode 0 (idle low, sample on rising edge)
//  tft_din  out  1  SPI MOSI, MSB first
// BEHAVIOUR
//  - Reset values: tft_bl=0, tft_rst=0, tft_dc=0, tft_cs=1, tft_clk=0, tft_din=0; FSM in RST_LOW.
//  - rst_n low at any time, including mid-byte: aborts the transfer and returns all outputs to reset values immediately.
//  - btn passes through a 2-flop synchroniser; the result is btn_s.
//  - FSM states and transitions:
//     RST_LOW:   tft_rst=0 for 10us/DELAY_DIV -> RST_WAIT
//     RST_WAIT:  tft_rst=1, wait 120ms/DELAY_DIV -> INIT
//     INIT:      walks the init ROM: cmd 0x11 (sleep out), wait 120ms/DELAY_DIV;
//                cmd 0x3A data 0x55; cmd 0x36 data 0x48; cmd 0x29 -> WIN.
//                tft_bl is set to 1 after the last bit of 0x29 and stays 1.
//     WIN:       latch colour from btn_s; cmd 0x2A data 00 00 00 EF; cmd 0x2B data 00 00 01 3F; cmd 0x2C -> FILL
//     FILL:      76800 pixels, each sent as 2 data bytes, high byte first -> IDLE
//     IDLE:      outputs quiescent (cs=1, clk=0); btn_s != latched colour -> WIN
//  - Colour map (RGB565): 00=0x0000 black, 01=0xF800 red, 10=0x07E0 green, 11=0x001F blue.
//  - A button change during FILL is ignored until FILL completes; the comparison is made in IDLE.
//  - Byte framing:
//     - tft_dc is valid and tft_cs falls one SPI half-period before the first tft_clk rise.
//     - 8 clocks per byte; tft_din changes only while tft_clk is low.
//     - tft_cs rises one half-period after the last falling edge and stays high at least one half-period between bytes.
//  - Pixel counter: 17 bits, terminal count 76799; byte counters never wrap silently.
// CONFIGURATION
//  - ILI9341_DEBOUNCE_EN defined: btn_s is accepted only after DEBOUNCE_CYC consecutive identical samples.
//  - Not defined: btn_s is the raw 2-flop synchronised value, with no further filtering.
// STRUCTURE
//  - Package ili9341_pkg holds:
//     - command constants (0x11, 0x3A, 0x36, 0x29, 0x2A, 0x2B, 0x2C)
//     - FSM state enum
//     - RGB565 colour constants
//     - the init-ROM entry typedef {is_data, byte, delay_ms}
//  - One sub-module, ili9341_spi_tx (byte serializer):
//     - inputs: start, dc, byte; outputs: busy, done, cs, clk, din
//     - parameterised by SPI_DIV
//  - The top holds the FSM, delay timer, pixel counter and button logic.
// TESTING
//  - Run with DELAY_DIV=1000, SPI_DIV=2, and the 10us reset pulse scaled to a minimum of 1 cycle.
//  1. rst_n low, then high -> tft_rst low for the scaled pulse, then high; tft_cs=1 and tft_bl=0 throughout the waits.
//  2. Decode SPI after reset -> bytes with dc in order:
//     - C11, C3A D55, C36 D48, C29, C2A D00 D00 D00 DEF, C2B D00 D00 D01 D3F, C2C.
//  3. btn=01 -> the first 4 FILL data bytes are F8 00 F8 00; the FILL byte count is exactly 153600; then IDLE with cs=1.
//  4. In IDLE, change btn 01->10 -> a new WIN/FILL sequence with pixels 07 E0; btn held constant -> no further SPI activity.
//  5. Assert rst_n mid-byte during FILL -> all outputs return to reset values immediately; after release the full init sequence restarts.
//  6. With ILI9341_DEBOUNCE_EN and a btn glitch shorter than DEBOUNCE_CYC -> no repaint; a stable change -> repaint.

Source files
------------

// File: rtl/ili9341_pkg.sv
// ili9341_pkg: command bytes, FSM states, RGB565 colours and ROM helpers for the ILI9341 driver
package ili9341_pkg;
  localparam logic [7:0] CMD_SLPOUT = 8'h11, CMD_COLMOD = 8'h3A, CMD_MADCTL = 8'h36, CMD_DISPON = 8'h29;
  localparam logic [7:0] CMD_CASET = 8'h2A, CMD_PASET = 8'h2B, CMD_RAMWR = 8'h2C;
  localparam logic [15:0] RGB_BLACK = 16'h0000, RGB_RED = 16'hF800, RGB_GREEN = 16'h07E0, RGB_BLUE = 16'h001F;
  localparam logic [3:0] INIT_LAST = 4'd5, WIN_LAST = 4'd10;
  typedef enum logic [2:0] {RST_LOW, RST_WAIT, INIT, WIN, FILL, IDLE} state_t;
  typedef struct packed {
    logic       is_data;
    logic [7:0] value;
    logic [7:0] delay_ms;
  } rom_entry_t;
  function automatic rom_entry_t init_rom(input logic [3:0] i);
    case (i)
      4'd0:    return {1'b0, CMD_SLPOUT, 8'd120};
      4'd1:    return {1'b0, CMD_COLMOD, 8'd0};
      4'd2:    return {1'b1, 8'h55, 8'd0};
      4'd3:    return {1'b0, CMD_MADCTL, 8'd0};
      4'd4:    return {1'b1, 8'h48, 8'd0};
      default: return {1'b0, CMD_DISPON, 8'd0};
    endcase
  endfunction
  // full-screen window: columns 0..239, rows 0..319, then memory write
  function automatic rom_entry_t win_rom(input logic [3:0] i);
    case (i)
      4'd0:    return {1'b0, CMD_CASET, 8'd0};
      4'd4:    return {1'b1, 8'hEF, 8'd0};
      4'd5:    return {1'b0, CMD_PASET, 8'd0};
      4'd8:    return {1'b1, 8'h01, 8'd0};
      4'd9:    return {1'b1, 8'h3F, 8'd0};
      4'd10:   return {1'b0, CMD_RAMWR, 8'd0};
      default: return {1'b1, 8'h00, 8'd0};
    endcase
  endfunction
  function automatic logic [15:0] rgb565(input logic [1:0] c);
    return c == 2'd0 ? RGB_BLACK : c == 2'd1 ? RGB_RED : c == 2'd2 ? RGB_GREEN : RGB_BLUE;
  endfunction
endpackage

// File: rtl/ili9341_spi_tx.sv
// ili9341_spi_tx: SPI mode-0 byte serializer, MSB first; cs framing plus a cs-high guard
// half-period before done, so back-to-back bytes always see cs high between them.
module ili9341_spi_tx
  #(parameter int SPI_DIV = 4)
  (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dc,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       dc_hold,
  output logic       cs,
  output logic       sclk,
  output logic       din
);
  logic [7:0] div, sh;
  logic [4:0] ph;
  logic tick;
  assign tick = div == 8'(SPI_DIV - 1);
  // ph: 0 setup, 1..16 alternating high/low halves, 17 cs-high guard
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      dc_hold <= 1'b0;
      cs <= 1'b1;
      sclk <= 1'b0;
      din <= 1'b0;
      sh <= '0;
      ph <= '0;
      div <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy <= 1'b1;
          cs <= 1'b0;
          dc_hold <= dc;
          sh <= data;
          din <= data[7];
          ph <= '0;
          div <= '0;
        end
      end else if (!tick) div <= div + 8'd1;
      else begin
        div <= '0;
        ph <= ph + 5'd1;
        sclk <= !ph[0] && ph < 5'd15;
        cs <= ph >= 5'd16;
        if (ph[0] && ph < 5'd14) begin
          sh <= sh << 1;
          din <= sh[6];
        end
        if (ph == 5'd17) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
endmodule

// File: rtl/ili9341_driver.sv
// ili9341_driver: ILI9341 SPI panel reset/init, then solid-colour fill chosen by btn, repainted on change.
// Define ILI9341_DEBOUNCE_EN to filter btn over DEBOUNCE_CYC samples; FILL_PIXELS is pixels per repaint.
module ili9341_driver
  import ili9341_pkg::*;
  #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SPI_DIV      = 4,
  parameter int DELAY_DIV    = 1,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int FILL_PIXELS  = 76800
  ) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic [1:0] btn,
  output logic       tft_bl,
  output logic       tft_rst,
  output logic       tft_dc,
  output logic       tft_cs,
  output logic       tft_clk,
  output logic       tft_din
);
  localparam int RST_CYC = CLK_HZ / 100_000 / DELAY_DIV > 0 ? CLK_HZ / 100_000 / DELAY_DIV : 1;
  localparam int MS_CYC = CLK_HZ / 1000 / DELAY_DIV > 0 ? CLK_HZ / 1000 / DELAY_DIV : 1;
  localparam logic [31:0] MS_W = 32'(MS_CYC);
  localparam logic [31:0] WAIT_LOAD = 32'(120 * MS_CYC - 1);
  localparam logic [16:0] TERM = 17'(FILL_PIXELS - 1);
  state_t state, nxt;
  logic [1:0] b1, b2, btn_s, colour;
  logic [3:0] idx;
  logic [31:0] tmr;
  logic [16:0] pix;
  logic lo, start, busy, done;
  logic [15:0] rgb;
  rom_entry_t ent;
`ifdef ILI9341_DEBOUNCE_EN
  logic [1:0] cand;
  logic [31:0] cnt;
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      cand <= '0;
      cnt <= '0;
      btn_s <= '0;
    end else if (b2 != cand) begin
      cand <= b2;
      cnt <= '0;
    end else if (cnt == 32'(DEBOUNCE_CYC - 1)) btn_s <= cand;
    else cnt <= cnt + 32'd1;
`else
  assign btn_s = b2;
`endif
  always_comb begin
    rgb = rgb565(colour);
    ent = state == INIT ? init_rom(idx) : state == WIN ? win_rom(idx) :
          rom_entry_t'({1'b1, lo ? rgb[7:0] : rgb[15:8], 8'd0});
    start = (state == INIT || state == WIN || state == FILL) && !busy && !done && tmr == '0;
    nxt = state;
    case (state)
      RST_LOW:  if (tmr == '0) nxt = RST_WAIT;
      RST_WAIT: if (tmr == '0) nxt = INIT;
      INIT:     if (done && idx == INIT_LAST) nxt = WIN;
      WIN:      if (done && idx == WIN_LAST) nxt = FILL;
      FILL:     if (done && lo && pix == TERM) nxt = IDLE;
      IDLE:     if (btn_s != colour) nxt = WIN;
      default:  nxt = RST_LOW;
    endcase
  end
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) state <= RST_LOW;
    else state <= nxt;
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      b1 <= '0;
      b2 <= '0;
      colour <= '0;
      idx <= '0;
      tmr <= 32'(RST_CYC - 1);
      pix <= '0;
      lo <= 1'b0;
      tft_rst <= 1'b0;
      tft_bl <= 1'b0;
    end else begin
      b1 <= btn;
      b2 <= b1;
      tmr <= tmr != '0 ? tmr - 32'd1 : '0;
      if (state == RST_LOW && nxt == RST_WAIT) begin
        tft_rst <= 1'b1;
        tmr <= WAIT_LOAD;
      end
      if (nxt == WIN && state != WIN) colour <= btn_s;
      if (done && state == INIT) begin
        idx <= idx == INIT_LAST ? 4'd0 : idx + 4'd1;
        if (ent.delay_ms != 8'd0) tmr <= 32'(ent.delay_ms) * MS_W - 32'd1;
        if (idx == INIT_LAST) tft_bl <= 1'b1;
      end
      if (done && state == WIN) idx <= idx == WIN_LAST ? 4'd0 : idx + 4'd1;
      if (done && state == FILL) begin
        lo <= !lo;
        if (lo) pix <= pix == TERM ? 17'd0 : pix + 17'd1;
      end
    end
  ili9341_spi_tx #(.SPI_DIV(SPI_DIV)) u_spi (
    .clk(sysclk),
    .rst_n(rst_n),
    .start(start),
    .dc(ent.is_data),
    .data(ent.value),
    .busy(busy),
    .done(done),
    .dc_hold(tft_dc),
    .cs(tft_cs),
    .sclk(tft_clk),
    .din(tft_din)
  );
endmodule

// File: tb/tb_ili9341_driver.sv
// tb_ili9341_driver: decodes the SPI pins into {dc,byte} and compares against the expected panel stream.
`timescale 1ns/1ps
module tb_ili9341_driver;
  localparam int SPI_DIV = 2, DELAY_DIV = 1000, CLK_HZ = 10_000_000, NPIX = 32;
  localparam int WAIT_CYC = 1200;
  localparam logic [15:0] RGB [4] = '{16'h0000, 16'hF800, 16'h07E0, 16'h001F};
  logic sysclk = 1'b0, rst_n = 1'b0;
  logic [1:0] btn = 2'd1;
  logic tft_bl, tft_rst, tft_dc, tft_cs, tft_clk, tft_din;
  int n_chk = 0, n_fail = 0;
  logic [8:0] rx[$], exp_q[$];
  int nb = 0, gap = 100, setup = 0, viol_din = 0, viol_gap = 0, viol_setup = 0;
  logic [7:0] sh = '0;
  logic dc_cap = 1'b0, p_cs = 1'b1, p_clk = 1'b0, p_din = 1'b0;
  logic [1:0] cur, a, b;

  ili9341_driver #(.CLK_HZ(CLK_HZ), .SPI_DIV(SPI_DIV), .DELAY_DIV(DELAY_DIV),
                   .DEBOUNCE_CYC(50), .FILL_PIXELS(NPIX)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .btn(btn), .tft_bl(tft_bl), .tft_rst(tft_rst),
    .tft_dc(tft_dc), .tft_cs(tft_cs), .tft_clk(tft_clk), .tft_din(tft_din));

  always #50 sysclk = ~sysclk;

  // pin-level SPI decoder and framing monitor
  always @(negedge sysclk) begin
    if (!rst_n) begin
      nb = 0;
      gap = 100;
    end else begin
      if (p_cs && !tft_cs) begin
        if (gap < SPI_DIV) viol_gap++;
        setup = 0;
      end
      if (!p_clk && tft_clk && !tft_cs) begin
        if (nb == 0) begin
          dc_cap = tft_dc;
          if (setup < SPI_DIV) viol_setup++;
        end
        sh = {sh[6:0], tft_din};
        nb++;
      end
      if (p_clk && tft_clk && p_din != tft_din) viol_din++;
      if (!p_cs && tft_cs) begin
        if (nb == 8) rx.push_back({dc_cap, sh});
        nb = 0;
        gap = 0;
      end
      if (tft_cs) gap++;
      else setup++;
    end
    p_cs = tft_cs;
    p_clk = tft_clk;
    p_din = tft_din;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(negedge sysclk);
    #1;
  endtask

  task automatic add(input logic dc, input logic [7:0] v);
    exp_q.push_back({dc, v});
  endtask

  task automatic push_init();
    add(0, 8'h11); add(0, 8'h3A); add(1, 8'h55); add(0, 8'h36); add(1, 8'h48); add(0, 8'h29);
  endtask

  task automatic push_paint(input logic [1:0] c);
    logic [15:0] px;
    px = RGB[c];
    add(0, 8'h2A); add(1, 8'h00); add(1, 8'h00); add(1, 8'h00); add(1, 8'hEF);
    add(0, 8'h2B); add(1, 8'h00); add(1, 8'h00); add(1, 8'h01); add(1, 8'h3F);
    add(0, 8'h2C);
    for (int i = 0; i < NPIX; i++) begin
      add(1, px[15:8]);
      add(1, px[7:0]);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int t = 0;
    while (rx.size() < exp_q.size() && t < budget) begin
      tick();
      t++;
    end
    check({tag, "_timeout"}, t < budget, 1);
    repeat (200) tick();
    check({tag, "_len"}, rx.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
      check($sformatf("%s_b%0d", tag, i), rx[i], exp_q[i]);
    rx.delete();
    exp_q.delete();
  endtask

  task automatic quiet(input string tag);
    int lows = 0;
    repeat (400) begin
      tick();
      if (!tft_cs) lows++;
    end
    check(tag, lows, 0);
  endtask

  task automatic boot(input string tag);
    int t = 0, blv = 0;
    check({tag, "_rst_pulse"}, tft_rst, 0);
    while (tft_cs && t < 5000) begin
      tick();
      t++;
      if (tft_bl) blv++;
    end
    check({tag, "_rst_high"}, tft_rst, 1);
    check({tag, "_rst_wait"}, t >= WAIT_CYC && t < 5000, 1);
    t = 0;
    while (rx.size() < 1 && t < 500) begin
      tick();
      t++;
    end
    t = 0;
    while (tft_cs && t < 5000) begin
      tick();
      t++;
      if (tft_bl) blv++;
    end
    check({tag, "_slpout_wait"}, t >= WAIT_CYC && t < 5000, 1);
    check({tag, "_bl_off"}, blv, 0);
  endtask

  initial begin
    repeat (5) tick();
    check("reset_outputs", {tft_bl, tft_rst, tft_dc, tft_cs, tft_clk, tft_din}, 6'b000100);
    push_init();
    push_paint(2'd1);
    rst_n = 1'b1;
    boot("boot");
    drain("boot_stream", 20000);
    check("bl_on", tft_bl, 1);
    quiet("idle_quiet");
    cur = 2'd2;
    btn = cur;
    push_paint(cur);
    drain("green", 10000);
    quiet("green_quiet");
    for (int k = 0; k < 3; k++) begin
      cur = 2'(cur + $urandom_range(1, 3));
      btn = cur;
      push_paint(cur);
      drain($sformatf("rand%0d", k), 10000);
    end
    a = 2'(cur + $urandom_range(1, 3));
    btn = a;
    push_paint(a);
    for (int t = 0; rx.size() < 17 && t < 5000; t++) tick();
    b = 2'(a + $urandom_range(1, 3));
    btn = b;
    push_paint(b);
    drain("midfill_change", 20000);
    cur = b;
    quiet("after_midfill_quiet");
`ifdef ILI9341_DEBOUNCE_EN
    btn = 2'(cur + 1);
    repeat (10) tick();
    btn = cur;
    quiet("glitch_ignored");
    cur = 2'(cur + 2);
    btn = cur;
    push_paint(cur);
    drain("debounced", 10000);
`endif
    cur = 2'(cur + $urandom_range(1, 3));
    btn = cur;
    begin
      int t = 0;
      while (!(rx.size() >= 20 && nb == 3) && t < 10000) begin
        tick();
        t++;
      end
      check("midbyte_reached", t < 10000, 1);
    end
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {tft_bl, tft_rst, tft_dc, tft_cs, tft_clk, tft_din}, 6'b000100);
    rx.delete();
    exp_q.delete();
    repeat (3) tick();
    check("abort_held", {tft_bl, tft_rst, tft_dc, tft_cs, tft_clk, tft_din}, 6'b000100);
    push_init();
    push_paint(cur);
    rst_n = 1'b1;
    boot("reboot");
    drain("reboot_stream", 20000);
    check("reboot_bl_on", tft_bl, 1);
    check("din_stable_clk_high", viol_din, 0);
    check("cs_gap", viol_gap, 0);
    check("cs_setup", viol_setup, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
